// File: rtl/axi_tester_pkg.sv
// Shared types for the AXI memory tester: FSM states, AXI response/burst
// codes and the master/slave AXI channel bundles.
package axi_tester_pkg;

  localparam int unsigned AXI_ID_W   = 4;
  localparam int unsigned AXI_ADDR_W = 16;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] INCR   = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_DONE
  } tester_state_e;

  // Master-to-slave signals of all five channels.
  typedef struct packed {
    logic [AXI_ID_W-1:0]   aw_id;
    logic [AXI_ADDR_W-1:0] aw_addr;
    logic [7:0]            aw_len;
    logic [2:0]            aw_size;
    logic [1:0]            aw_burst;
    logic                  aw_valid;
    logic [AXI_DATA_W-1:0] w_data;
    logic [AXI_STRB_W-1:0] w_strb;
    logic                  w_last;
    logic                  w_valid;
    logic                  b_ready;
    logic [AXI_ID_W-1:0]   ar_id;
    logic [AXI_ADDR_W-1:0] ar_addr;
    logic [7:0]            ar_len;
    logic [2:0]            ar_size;
    logic [1:0]            ar_burst;
    logic                  ar_valid;
    logic                  r_ready;
  } axi_mosi_t;

  // Slave-to-master signals of all five channels.
  typedef struct packed {
    logic                  aw_ready;
    logic                  w_ready;
    logic [AXI_ID_W-1:0]   b_id;
    logic [1:0]            b_resp;
    logic                  b_valid;
    logic                  ar_ready;
    logic [AXI_ID_W-1:0]   r_id;
    logic [AXI_DATA_W-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_last;
    logic                  r_valid;
  } axi_miso_t;

endpackage

// File: rtl/axi_pattern_gen.sv
// Beat counter and test-pattern adder shared by the write and read phases.
// Ports:
//   clk_i, rst_i  clock, async active-high reset
//   load_i        capture seed_i and restart at beat 0
//   seed_i        pattern seed
//   rewind_i      restart at beat 0 with the captured seed
//   adv_i         step to the next beat
//   pattern_o     seed + beat (registered)
//   last_o        high while on beat BURST_LEN-1 (registered)
module axi_pattern_gen #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BURST_LEN = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] seed_i,
  input  logic              rewind_i,
  input  logic              adv_i,
  output logic [DATA_W-1:0] pattern_o,
  output logic              last_o
);

  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [DATA_W-1:0] pat_q, pat_d;
  logic              last_q, last_d;

  // Pattern tracks seed+beat incrementally so no wide adder sits on the beat.
  always_comb begin
    beat_d = beat_q;
    seed_d = seed_q;
    pat_d  = pat_q;
    if (load_i) begin
      seed_d = seed_i;
      beat_d = '0;
      pat_d  = seed_i;
    end else if (rewind_i) begin
      beat_d = '0;
      pat_d  = seed_q;
    end else if (adv_i) begin
      beat_d = beat_q + BEAT_W'(1);
      pat_d  = pat_q + DATA_W'(1);
    end
    last_d = (beat_d == BEAT_W'(BURST_LEN - 1));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_q <= '0;
      seed_q <= '0;
      pat_q  <= '0;
      last_q <= 1'b0;
    end else begin
      beat_q <= beat_d;
      seed_q <= seed_d;
      pat_q  <= pat_d;
      last_q <= last_d;
    end
  end

  assign pattern_o = pat_q;
  assign last_o    = last_q;

endmodule

// File: rtl/axi_mem_tester.sv
// AXI master that writes one INCR burst of seed+beat to BASE_ADDR, reads it
// back and counts every response, ID, data and rlast discrepancy.
// Ports:
//   clk_i, rst_i  clock, async active-high reset
//   start_i       launch one write-then-read test (IDLE only)
//   seed_i        pattern seed, sampled at start
//   out_mosi_o    AXI master outputs
//   out_miso_i    AXI slave responses
//   busy_o        high outside IDLE
//   done_o        one-cycle pulse at test end
//   pass_o        last test saw zero errors, held until next start
//   err_cnt_o     saturating error count
module axi_mem_tester
  import axi_tester_pkg::*;
#(
  parameter int unsigned ID_W_WIDTH     = 4,
  parameter int unsigned ID_R_WIDTH     = 4,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN      = 8,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned TX_ID          = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [AXI_DATA_WIDTH-1:0] seed_i,
  output axi_mosi_t                 out_mosi_o,
  input  axi_miso_t                 out_miso_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      pass_o,
  output logic [15:0]               err_cnt_o
);

  tester_state_e state_q, state_d;

  logic aw_valid_q, aw_valid_d;
  logic w_valid_q, w_valid_d;
  logic b_ready_q, b_ready_d;
  logic ar_valid_q, ar_valid_d;
  logic r_ready_q, r_ready_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic pass_q, pass_d;
  logic [15:0] err_q, err_d;

  logic                      pg_load, pg_rewind, pg_adv;
  logic [AXI_DATA_WIDTH-1:0] pattern;
  logic                      last_beat;

  logic       aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [2:0] new_errs;
  logic [16:0] err_sum;

  axi_pattern_gen #(
    .DATA_W    (AXI_DATA_WIDTH),
    .BURST_LEN (BURST_LEN)
  ) u_pattern_gen (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (pg_load),
    .seed_i    (seed_i),
    .rewind_i  (pg_rewind),
    .adv_i     (pg_adv),
    .pattern_o (pattern),
    .last_o    (last_beat)
  );

  assign aw_hs = aw_valid_q & out_miso_i.aw_ready;
  assign w_hs  = w_valid_q  & out_miso_i.w_ready;
  assign b_hs  = b_ready_q  & out_miso_i.b_valid;
  assign ar_hs = ar_valid_q & out_miso_i.ar_ready;
  assign r_hs  = r_ready_q  & out_miso_i.r_valid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state, error accounting and next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    pass_d    = pass_q;
    pg_load   = 1'b0;
    pg_rewind = 1'b0;
    pg_adv    = 1'b0;
    new_errs  = 3'd0;
    err_sum   = 17'd0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          pg_load = 1'b1;
          err_d   = 16'd0;
          pass_d  = 1'b0;
          state_d = ST_AW;
        end
      end
      ST_AW: if (aw_hs) state_d = ST_W;
      ST_W: begin
        if (w_hs) begin
          if (last_beat) state_d = ST_B;
          else           pg_adv  = 1'b1;
        end
      end
      ST_B: begin
        if (b_hs) begin
          pg_rewind = 1'b1;
          if ((out_miso_i.b_resp != OKAY) ||
              (out_miso_i.b_id[ID_W_WIDTH-1:0] != ID_W_WIDTH'(TX_ID)))
            new_errs = 3'd1;
          state_d = ST_AR;
        end
      end
      ST_AR: if (ar_hs) state_d = ST_R;
      ST_R: begin
        if (r_hs) begin
          new_errs = 3'((out_miso_i.r_data[AXI_DATA_WIDTH-1:0] != pattern))
                   + 3'((out_miso_i.r_resp != OKAY))
                   + 3'((out_miso_i.r_id[ID_R_WIDTH-1:0] != ID_R_WIDTH'(TX_ID)))
                   + 3'((out_miso_i.r_last != last_beat));
          if (last_beat) state_d = ST_DONE;
          else           pg_adv  = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Saturating accumulate; the IDLE clear is never combined with new errors.
    if (new_errs != 3'd0) begin
      err_sum = 17'(err_q) + 17'(new_errs);
      err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    if (state_d == ST_DONE) pass_d = (err_d == 16'd0);

    aw_valid_d = (state_d == ST_AW);
    w_valid_d  = (state_d == ST_W);
    b_ready_d  = (state_d == ST_B);
    ar_valid_d = (state_d == ST_AR);
    r_ready_d  = (state_d == ST_R);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= 16'd0;
    end else begin
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      b_ready_q  <= b_ready_d;
      ar_valid_q <= ar_valid_d;
      r_ready_q  <= r_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
    end
  end

  // Address/control fields are constant, so they are stable through any stall.
  always_comb begin
    out_mosi_o          = '0;
    out_mosi_o.aw_id    = AXI_ID_W'(ID_W_WIDTH'(TX_ID));
    out_mosi_o.aw_addr  = AXI_ADDR_W'(ADDR_WIDTH'(BASE_ADDR));
    out_mosi_o.aw_len   = 8'(BURST_LEN - 1);
    out_mosi_o.aw_size  = 3'($clog2(AXI_DATA_WIDTH / 8));
    out_mosi_o.aw_burst = INCR;
    out_mosi_o.aw_valid = aw_valid_q;
    out_mosi_o.w_data   = AXI_DATA_W'(pattern);
    out_mosi_o.w_strb   = '1;
    out_mosi_o.w_last   = w_valid_q & last_beat;
    out_mosi_o.w_valid  = w_valid_q;
    out_mosi_o.b_ready  = b_ready_q;
    out_mosi_o.ar_id    = AXI_ID_W'(ID_R_WIDTH'(TX_ID));
    out_mosi_o.ar_addr  = AXI_ADDR_W'(ADDR_WIDTH'(BASE_ADDR));
    out_mosi_o.ar_len   = 8'(BURST_LEN - 1);
    out_mosi_o.ar_size  = 3'($clog2(AXI_DATA_WIDTH / 8));
    out_mosi_o.ar_burst = INCR;
    out_mosi_o.ar_valid = ar_valid_q;
    out_mosi_o.r_ready  = r_ready_q;
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign pass_o    = pass_q;
  assign err_cnt_o = err_q;

endmodule

// File: tb/tb_axi_mem_tester.sv
// Testbench for axi_mem_tester: a stalling, fault-injecting AXI RAM slave and
// a burst-level model of the expected write data and error count.
module tb_axi_mem_tester;
  import axi_tester_pkg::*;

  localparam int LEN = 8;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] seed;
  axi_mosi_t   mosi;
  axi_miso_t   miso;
  logic        busy, done, pass;
  logic [15:0] err_cnt;

  int checks = 0;
  int errors = 0;

  // Slave configuration for the current test.
  int          cfg_stall;
  int          cfg_cbeat;
  logic [31:0] cfg_cval;
  logic [1:0]  cfg_bresp;
  int          cfg_elast;
  logic [31:0] exp_seed;

  // Slave memory and what was actually returned on R.
  logic [31:0] mem        [LEN];
  logic [31:0] sent_rdata [LEN];
  logic        sent_rlast [LEN];
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;

  axi_mem_tester dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .seed_i     (seed),
    .out_mosi_o (mosi),
    .out_miso_i (miso),
    .busy_o     (busy),
    .done_o     (done),
    .pass_o     (pass),
    .err_cnt_o  (err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int stall_val();
    return (cfg_stall != 0) ? int'($urandom_range(0, 3)) : 0;
  endfunction

  // Errors the tester must report, from what the slave actually returned.
  function automatic int model_errs();
    int e;
    e = (cfg_bresp != OKAY) ? 1 : 0;
    for (int i = 0; i < LEN; i++) begin
      if (sent_rdata[i] != exp_seed + 32'(i)) e++;
      if (sent_rlast[i] != (i == LEN - 1)) e++;
    end
    return e;
  endfunction

  // AXI RAM slave, evaluated on the falling edge.
  initial begin : slave
    axi_mosi_t   pm;
    int          aw_st, w_st, ar_st, r_st, r_beat;
    logic        r_active, b_pending, rl;
    logic [31:0] d;
    miso = '0;
    pm = '0;
    aw_st = 0; w_st = 0; ar_st = 0; r_st = 0; r_beat = 0;
    r_active = 1'b0; b_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        miso = '0;
        pm = '0;
        aw_st = 0; w_st = 0; ar_st = 0; r_st = 0; r_beat = 0;
        r_active = 1'b0; b_pending = 1'b0;
      end else begin
        // Handshakes completed at the last rising edge.
        if (pm.aw_valid && miso.aw_ready) begin
          aw_cnt++;
          check("aw_addr", 32'(pm.aw_addr), 32'h0);
          check("aw_ctl", 32'({pm.aw_id, pm.aw_len, pm.aw_size, pm.aw_burst}),
                32'({4'h0, 8'd7, 3'd2, INCR}));
          miso.aw_ready = 1'b0;
          aw_st = stall_val();
        end else if (pm.aw_valid) begin
          check("aw_stable", 32'({mosi.aw_valid, mosi.aw_addr, mosi.aw_len}),
                32'({1'b1, pm.aw_addr, pm.aw_len}));
        end

        if (pm.w_valid && miso.w_ready) begin
          check("wdata", pm.w_data, exp_seed + 32'(w_cnt));
          check("wlast", 32'(pm.w_last), 32'(w_cnt == LEN - 1));
          check("wstrb", 32'(pm.w_strb), 32'hF);
          if (w_cnt < LEN) mem[w_cnt] = pm.w_data;
          w_cnt++;
          miso.w_ready = 1'b0;
          w_st = stall_val();
          if (pm.w_last) b_pending = 1'b1;
        end else if (pm.w_valid) begin
          check("w_stable", mosi.w_data, pm.w_data);
          check("w_hold", 32'({mosi.w_valid, mosi.w_last}), 32'({1'b1, pm.w_last}));
        end

        if (miso.b_valid && pm.b_ready) begin
          b_cnt++;
          miso.b_valid = 1'b0;
        end

        if (pm.ar_valid && miso.ar_ready) begin
          ar_cnt++;
          check("ar_addr", 32'(pm.ar_addr), 32'h0);
          check("ar_ctl", 32'({pm.ar_id, pm.ar_len, pm.ar_size, pm.ar_burst}),
                32'({4'h0, 8'd7, 3'd2, INCR}));
          miso.ar_ready = 1'b0;
          ar_st = stall_val();
          r_active = 1'b1;
          r_beat = 0;
          r_st = stall_val();
        end else if (pm.ar_valid) begin
          check("ar_stable", 32'({mosi.ar_valid, mosi.ar_addr, mosi.ar_len}),
                32'({1'b1, pm.ar_addr, pm.ar_len}));
        end

        if (miso.r_valid && pm.r_ready) begin
          r_cnt++;
          miso.r_valid = 1'b0;
          r_beat++;
          r_st = stall_val();
          if (r_beat == LEN) r_active = 1'b0;
        end

        // Present ready/valid for the next rising edge.
        if (mosi.aw_valid && !miso.aw_ready) begin
          if (aw_st == 0) miso.aw_ready = 1'b1; else aw_st--;
        end
        if (mosi.w_valid && !miso.w_ready) begin
          if (w_st == 0) miso.w_ready = 1'b1; else w_st--;
        end
        if (mosi.ar_valid && !miso.ar_ready) begin
          if (ar_st == 0) miso.ar_ready = 1'b1; else ar_st--;
        end
        if (b_pending && !miso.b_valid) begin
          miso.b_valid = 1'b1;
          miso.b_resp  = cfg_bresp;
          miso.b_id    = '0;
          b_pending    = 1'b0;
        end
        if (r_active && !miso.r_valid) begin
          if (r_st == 0) begin
            d  = (r_beat == cfg_cbeat) ? cfg_cval : mem[r_beat];
            rl = (cfg_elast >= 0) ? (r_beat == cfg_elast) : (r_beat == LEN - 1);
            sent_rdata[r_beat] = d;
            sent_rlast[r_beat] = rl;
            miso.r_valid = 1'b1;
            miso.r_data  = d;
            miso.r_last  = rl;
            miso.r_resp  = OKAY;
            miso.r_id    = '0;
          end else begin
            r_st--;
          end
        end
        pm = mosi;
      end
    end
  end

  task automatic setup(input logic [31:0] s, input int stall, input int cbeat,
                       input logic [31:0] cval, input logic [1:0] bresp, input int elast);
    cfg_stall = stall;
    cfg_cbeat = cbeat;
    cfg_cval  = cval;
    cfg_bresp = bresp;
    cfg_elast = elast;
    exp_seed  = s;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    for (int i = 0; i < LEN; i++) begin
      sent_rdata[i] = 32'h0;
      sent_rlast[i] = 1'b0;
    end
  endtask

  // One full test; called at negedge+1.
  task automatic run_test(input logic [31:0] s, input int stall, input int cbeat,
                          input logic [31:0] cval, input logic [1:0] bresp, input int elast);
    int n;
    int exp_e;
    setup(s, stall, cbeat, cval, bresp, elast);
    seed  = s;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("err_cleared", 32'(err_cnt), 32'd0);
    check("pass_cleared", 32'(pass), 32'd0);
    n = 0;
    while (!done && n < 1000) begin
      @(negedge clk); #1;
      n++;
      // start outside IDLE must have no effect
      start = (n == 5);
    end
    start = 1'b0;
    if (!done) begin
      check("done_timeout", 32'd0, 32'd1);
      rst = 1'b1;
      @(negedge clk); #1;
      @(negedge clk); #1;
      rst = 1'b0;
    end else begin
      exp_e = model_errs();
      check("err_cnt", 32'(err_cnt), 32'(exp_e));
      check("pass", 32'(pass), 32'(exp_e == 0));
      check("r_beats_at_done", 32'(r_cnt), 32'(LEN));
      check("w_beats", 32'(w_cnt), 32'(LEN));
      check("addr_hs", 32'({aw_cnt[7:0], b_cnt[7:0], ar_cnt[7:0]}), 32'h010101);
      check("busy_in_done", 32'(busy), 32'd1);
      @(negedge clk); #1;
      check("done_pulse", 32'(done), 32'd0);
      check("busy_idle", 32'(busy), 32'd0);
      check("pass_held", 32'(pass), 32'(exp_e == 0));
    end
  endtask

  initial begin : main
    int n;
    rst   = 1'b1;
    start = 1'b0;
    seed  = 32'h0;
    setup(32'h0, 0, -1, 32'h0, OKAY, -1);
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    check("rst_valids", 32'({mosi.aw_valid, mosi.w_valid, mosi.b_ready, mosi.ar_valid, mosi.r_ready}), 32'd0);

    // Start right after reset release, against a plain RAM.
    rst = 1'b0;
    run_test(32'h1000, 0, -1, 32'h0, OKAY, -1);
    check("mem0", mem[0], 32'h1000);
    check("mem7", mem[7], 32'h1007);
    check("basic_err", 32'(err_cnt), 32'd0);
    check("basic_pass", 32'(pass), 32'd1);

    // Random handshake stalls: same result.
    run_test(32'h1000, 1, -1, 32'h0, OKAY, -1);
    check("stall_err", 32'(err_cnt), 32'd0);
    check("stall_pass", 32'(pass), 32'd1);

    // Corrupted read data on beat 3.
    run_test(32'h1000, 0, 3, 32'hDEAD, OKAY, -1);
    check("corrupt_err", 32'(err_cnt), 32'd1);
    check("corrupt_pass", 32'(pass), 32'd0);

    // SLVERR plus rlast on beat 6 instead of 7.
    run_test(32'h1000, 0, -1, 32'h0, SLVERR, 6);
    check("bresp_rlast_err", 32'(err_cnt), 32'd3);
    check("bresp_rlast_pass", 32'(pass), 32'd0);

    // Reset while beat 4 is on the W channel.
    setup(32'h55, 0, -1, 32'h0, OKAY, -1);
    seed  = 32'h55;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(w_cnt == 4 && mosi.w_valid) && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check("w_beat4_reached", 32'(w_cnt == 4 && mosi.w_valid), 32'd1);
    check("w_beat4_data", mosi.w_data, 32'h59);
    rst = 1'b1;
    #1;
    check("midrst_valids", 32'({mosi.aw_valid, mosi.w_valid, mosi.b_ready, mosi.ar_valid, mosi.r_ready}), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_err_pass_done", 32'({err_cnt, pass, done}), 32'd0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst = 1'b0;
    run_test(32'h2000, 0, -1, 32'h0, OKAY, -1);
    check("after_rst_pass", 32'(pass), 32'd1);

    // Pattern wrap across 2^32.
    run_test(32'hFFFF_FFFE, 0, -1, 32'h0, OKAY, -1);
    check("wrap_mem2", mem[2], 32'h0);
    check("wrap_pass", 32'(pass), 32'd1);

    // Randomized seeds, stalls and faults.
    for (int t = 0; t < 8; t++) begin
      logic [31:0] rs;
      int          cb;
      int          el;
      logic [1:0]  br;
      rs = $urandom;
      cb = int'($urandom_range(0, LEN));
      br = ($urandom_range(0, 2) == 0) ? SLVERR : OKAY;
      el = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, LEN - 1)) : -1;
      run_test(rs, 1, cb, $urandom, br, el);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
